// File: rtl/bombman_pkg.sv
// Shared grid constants, bomb/game state encodings and cell helpers for the bomb placer slice.
package bombman_pkg;

  localparam int unsigned GRID_DIM  = 10;
  localparam int unsigned CELL_MIN  = 1;
  localparam int unsigned CELL_MAX  = 8;
  localparam int unsigned NUM_CELLS = GRID_DIM * GRID_DIM;

  typedef enum logic [1:0] {
    BOMB_NONE    = 2'd0,
    BOMB_PLACED  = 2'd1,
    BOMB_ARMED   = 2'd2,
    BOMB_EXPLODE = 2'd3
  } bomb_state_t;

  typedef enum logic [1:0] {
    GAME_RUNNING = 2'd0,
    A_WINS       = 2'd1,
    B_WINS       = 2'd2,
    DRAW         = 2'd3
  } game_state_t;

  function automatic logic [6:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    return 7'(x) * 7'd10 + 7'(y);
  endfunction

  function automatic logic coord_ok(input logic [3:0] x, input logic [3:0] y);
    return (x >= 4'(CELL_MIN)) && (x <= 4'(CELL_MAX)) &&
           (y >= 4'(CELL_MIN)) && (y <= 4'(CELL_MAX));
  endfunction

  // One bit per interior cell; border rows/columns are never allowed to hold a bomb.
  function automatic logic [NUM_CELLS-1:0] inner_mask();
    logic [NUM_CELLS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      m[i] = coord_ok(4'(i / GRID_DIM), 4'(i % GRID_DIM));
    end
    return m;
  endfunction

  function automatic logic [6:0] popcount(input logic [NUM_CELLS-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      c = c + 7'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/bomb_placer_place_req_gen.sv
// Per-player place-request generator: button rising-edge detect gated by a post-placement cooldown.
module place_req_gen #(
  parameter int unsigned COOLDOWN_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic accept,
  output logic req
);

  localparam int unsigned CW = (COOLDOWN_CYCLES < 1) ? 1 : $clog2(COOLDOWN_CYCLES + 1);

  logic          btnPrev;
  logic [CW-1:0] coolCnt;

  assign req = btn & ~btnPrev & (coolCnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      btnPrev <= 1'b0;
      coolCnt <= '0;
    end else begin
      btnPrev <= btn;
      if (accept) begin
        coolCnt <= CW'(COOLDOWN_CYCLES);
      end else if (coolCnt != '0) begin
        coolCnt <= coolCnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bomb_placer.sv
// Bomb map owner: merges timer ticks with player placements, tracks owners and per-player limits.
// Optional owner tracking / bomb limit enabled by defining BOMB_OWNER_LIMIT_EN.
module bomb_placer
  import bombman_pkg::*;
#(
  parameter int unsigned MAX_BOMBS       = 2,
  parameter int unsigned COOLDOWN_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bomb_tick,
  input  logic         btnA,
  input  logic         btnB,
  input  logic [3:0]   playerAx,
  input  logic [3:0]   playerAy,
  input  logic [3:0]   playerBx,
  input  logic [3:0]   playerBy,
  input  logic [1:0]   game_state,
  input  logic [99:0]  i_updatedBombMap_0,
  input  logic [99:0]  i_updatedBombMap_1,
  output logic [99:0]  o_curBombMap_0,
  output logic [99:0]  o_curBombMap_1,
  output logic         o_placedA,
  output logic         o_placedB,
  output logic [2:0]   o_bombCntA,
  output logic [2:0]   o_bombCntB
);

  localparam logic [NUM_CELLS-1:0] INNER = inner_mask();
  localparam logic [NUM_CELLS-1:0] ONE   = NUM_CELLS'(1);

  logic [99:0] map0, map1;
  logic [99:0] postMap0, postMap1, postOcc;
  logic [99:0] nextMap0, nextMap1;
  logic [99:0] onehotA, onehotB;
  logic [6:0]  idxA, idxB;
  logic        okA, okB, freeA, freeB, limitOkA, limitOkB;
  logic        reqA, reqB, accA, accB, running;
  logic        placedA, placedB;

  place_req_gen #(.COOLDOWN_CYCLES(COOLDOWN_CYCLES)) u_reqA (
    .clk(clk), .rst(rst), .btn(btnA), .accept(accA), .req(reqA)
  );

  place_req_gen #(.COOLDOWN_CYCLES(COOLDOWN_CYCLES)) u_reqB (
    .clk(clk), .rst(rst), .btn(btnB), .accept(accB), .req(reqB)
  );

  // Arbitration sees the post-tick map so a cell cleared by this tick is already placeable.
  always_comb begin
    postMap0 = bomb_tick ? (i_updatedBombMap_0 & INNER) : map0;
    postMap1 = bomb_tick ? (i_updatedBombMap_1 & INNER) : map1;
    postOcc  = postMap0 | postMap1;
    running  = (game_state == GAME_RUNNING);
    idxA     = cell_idx(playerAx, playerAy);
    idxB     = cell_idx(playerBx, playerBy);
    okA      = coord_ok(playerAx, playerAy);
    okB      = coord_ok(playerBx, playerBy);
    onehotA  = okA ? (ONE << idxA) : '0;
    onehotB  = okB ? (ONE << idxB) : '0;
    freeA    = (postOcc & onehotA) == '0;
    freeB    = (postOcc & onehotB) == '0;
    accA     = reqA & running & okA & freeA & limitOkA;
    accB     = reqB & running & okB & freeB & limitOkB & ~(accA & (idxA == idxB));
    nextMap0 = postMap0 | (accA ? onehotA : '0) | (accB ? onehotB : '0);
    nextMap1 = postMap1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      map0    <= '0;
      map1    <= '0;
      placedA <= 1'b0;
      placedB <= 1'b0;
    end else begin
      map0    <= nextMap0;
      map1    <= nextMap1;
      placedA <= accA;
      placedB <= accB;
    end
  end

`ifdef BOMB_OWNER_LIMIT_EN
  logic [99:0] ownA, ownB, postOwnA, postOwnB, nextOwnA, nextOwnB, nextOcc;
  logic [6:0]  postCntA, postCntB, nextCntA, nextCntB;
  logic [2:0]  cntA, cntB;

  // Masking owners with occupancy drops ownership of any cell the tick emptied.
  always_comb begin
    postOwnA = ownA & postOcc;
    postOwnB = ownB & postOcc;
    postCntA = popcount(postOwnA);
    postCntB = popcount(postOwnB);
    limitOkA = postCntA < 7'(MAX_BOMBS);
    limitOkB = postCntB < 7'(MAX_BOMBS);
    nextOcc  = nextMap0 | nextMap1;
    nextOwnA = (postOwnA | (accA ? onehotA : '0)) & nextOcc;
    nextOwnB = (postOwnB | (accB ? onehotB : '0)) & nextOcc;
    nextCntA = popcount(nextOwnA);
    nextCntB = popcount(nextOwnB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ownA <= '0;
      ownB <= '0;
      cntA <= '0;
      cntB <= '0;
    end else begin
      ownA <= nextOwnA;
      ownB <= nextOwnB;
      cntA <= (nextCntA > 7'd7) ? 3'd7 : nextCntA[2:0];
      cntB <= (nextCntB > 7'd7) ? 3'd7 : nextCntB[2:0];
    end
  end

  assign o_bombCntA = cntA;
  assign o_bombCntB = cntB;
`else
  assign limitOkA   = 1'b1;
  assign limitOkB   = 1'b1;
  assign o_bombCntA = '0;
  assign o_bombCntB = '0;
`endif

  assign o_curBombMap_0 = map0;
  assign o_curBombMap_1 = map1;
  assign o_placedA      = placedA;
  assign o_placedB      = placedB;

endmodule
